// File: rtl/operand_fetch.sv
// Operand-fetch stage ahead of the ALU: gathers operand a from the register file and operand b
// from the register file (RR) or a variable-latency data-memory read (MR), then hands off.
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef OPCODE_W
`define OPCODE_W 5
`endif

module operand_fetch #(
  parameter int unsigned DATA_W   = `DATA_W,
  parameter int unsigned OPCODE_W = `OPCODE_W,
  parameter int unsigned REG_W    = 3,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_op,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic [REG_W-1:0]    rf_ra0,
  output logic [REG_W-1:0]    rf_ra1,
  input  logic [DATA_W-1:0]   rf_rd0,
  input  logic [DATA_W-1:0]   rf_rd1,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_a,
  output logic [DATA_W-1:0]   out_b,
  output logic [OPCODE_W-1:0] out_s,
  output logic [REG_W-1:0]    out_rd
);

  // def.h layout: RR_* occupy 0x00-0x0F, MR_* occupy 0x10-0x17, the rest is reserved.
  localparam logic [OPCODE_W-1:0] MrFirst = OPCODE_W'(5'h10);
  localparam logic [OPCODE_W-1:0] MrLast  = OPCODE_W'(5'h17);

  typedef enum logic [1:0] {StIdle, StMemWait, StFull} state_e;

  state_e state_q, state_d;

  logic                accept;
  logic                is_mr;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   out_a_q, out_a_d;
  logic [DATA_W-1:0]   out_b_q, out_b_d;
  logic [OPCODE_W-1:0] out_s_q, out_s_d;
  logic [REG_W-1:0]    out_rd_q, out_rd_d;

  assign rf_ra0 = in_rd;
  assign rf_ra1 = in_rs;
  assign is_mr  = (in_op >= MrFirst) && (in_op <= MrLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = is_mr ? StMemWait : StFull;
      end
      StMemWait: begin
        if (mem_ack) state_d = StFull;
      end
      StFull: begin
        if (out_ready) begin
          if (accept) state_d = is_mr ? StMemWait : StFull;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // in_ready is held low while reset is asserted so nothing is taken during reset.
  always_comb begin
    in_ready  = rst_n && ((state_q == StIdle) || ((state_q == StFull) && out_ready));
    out_valid = (state_q == StFull);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_s_d    = out_s_q;
    out_rd_d   = out_rd_q;
    if (accept) begin
      out_s_d  = in_op;
      out_rd_d = in_rd;
      out_a_d  = rf_rd0;
      if (is_mr) begin
        mem_addr_d = in_addr;
        mem_req_d  = 1'b1;
      end else begin
        out_b_d = rf_rd1;
      end
    end else if ((state_q == StMemWait) && mem_ack) begin
      out_b_d   = mem_rdata;
      mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_s_q    <= '0;
      out_rd_q   <= '0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_s_q    <= out_s_d;
      out_rd_q   <= out_rd_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign out_a    = out_a_q;
  assign out_b    = out_b_q;
  assign out_s    = out_s_q;
  assign out_rd   = out_rd_q;

endmodule
